uart_rx_ovs: RTL and testbench

UART_RX_OVS -- requirements
Module: uart_rx_ovs

---
 rtl/uart_rx_ovs.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around each bit centre.
module uart_rx_ovs #(
  parameter int OVS        = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       BAUD_TICK,
  input  logic       Rx,
  input  logic       CLR_Rec,
  output logic [7:0] Data_Rx,
  output logic       Data_Ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MID  = CW'(OVS/2);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS-1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_PRE  = CW'(OVS/2-1);
  localparam logic [CW-1:0] CNT_SAMP = CW'(OVS/2+1);
`else
  localparam logic [CW-1:0] CNT_SAMP = CNT_MID;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Nonzero result means the frame's parity does not match the configured sense.
  function automatic logic parity_calc(input logic [7:0] d, input logic p, input logic odd);
    return (^d) ^ p ^ odd;
  endfunction

  state_t      state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]  bit_idx_r, bit_idx_s;
  logic [7:0]  shift_r, shift_s;
  logic        par_r, par_s;
  logic        stop_r, stop_s;
  logic        done_r, done_s;
  logic        rx_meta_r, rx_sync_r, prev_r;
  logic        bit_s, wrap_s, samp_s;

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= Rx;
      rx_sync_r <= rx_meta_r;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic samp_a_r, samp_b_r;

  // Early samples for the majority vote, taken just before and at the bit centre.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      samp_a_r <= 1'b1;
      samp_b_r <= 1'b1;
    end else if (BAUD_TICK && (cnt_r == CNT_PRE)) begin
      samp_a_r <= rx_sync_r;
      samp_b_r <= samp_b_r;
    end else if (BAUD_TICK && (cnt_r == CNT_MID)) begin
      samp_a_r <= samp_a_r;
      samp_b_r <= rx_sync_r;
    end else begin
      samp_a_r <= samp_a_r;
      samp_b_r <= samp_b_r;
    end
  end

  assign bit_s = (samp_a_r & samp_b_r) | (samp_a_r & rx_sync_r) | (samp_b_r & rx_sync_r);
`else
  assign bit_s = rx_sync_r;
`endif

  assign wrap_s = (cnt_r == CNT_LAST);
  assign samp_s = (cnt_r == CNT_SAMP);

  // Frame FSM next-state: moves only on baud ticks.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    par_s     = par_r;
    stop_s    = stop_r;
    done_s    = 1'b0;
    if (BAUD_TICK) begin
      if (wrap_s) begin
        cnt_s = CNT_ZERO;
      end else begin
        cnt_s = cnt_r + CNT_ONE;
      end
      case (state_r)
        IDLE: begin
          cnt_s = CNT_ZERO;
          if (!rx_sync_r && prev_r) begin
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          if (samp_s && bit_s) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end else if (wrap_s) begin
            state_s   = DATA;
            bit_idx_s = 3'd0;
          end else begin
            state_s = START;
          end
        end
        DATA: begin
          if (samp_s) begin
            shift_s = {bit_s, shift_r[7:1]};
          end else begin
            shift_s = shift_r;
          end
          if (wrap_s && (bit_idx_r == 3'd7)) begin
            state_s = PARITY;
          end else if (wrap_s) begin
            bit_idx_s = bit_idx_r + 3'd1;
          end else begin
            state_s = DATA;
          end
        end
        PARITY: begin
          if (samp_s) begin
            par_s = bit_s;
          end else begin
            par_s = par_r;
          end
          if (wrap_s) begin
            state_s = STOP;
          end else begin
            state_s = PARITY;
          end
        end
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (samp_s) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
            stop_s  = bit_s;
            done_s  = 1'b1;
          end else begin
            state_s = STOP;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Frame FSM state, counters and previous-tick line sample.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
      stop_r    <= 1'b1;
      done_r    <= 1'b0;
      prev_r    <= 1'b1;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      par_r     <= par_s;
      stop_r    <= stop_s;
      done_r    <= done_s;
      prev_r    <= BAUD_TICK ? rx_sync_r : prev_r;
    end
  end

  // Result and status registers; a completing frame takes priority over CLR_Rec.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      Data_Rx    <= 8'h00;
      Data_Ready <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done_r) begin
      Data_Rx    <= shift_r;
      Data_Ready <= 1'b1;
      parity_err <= parity_calc(shift_r, par_r, PARITY_ODD);
      frame_err  <= ~stop_r;
      overrun    <= Data_Ready & ~CLR_Rec;
    end else if (CLR_Rec) begin
      Data_Ready <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      Data_Ready <= Data_Ready;
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed self-checking bench for uart_rx_ovs (OVS=16, even parity, tick every 4 CLK).
module tb_uart_rx_ovs;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       BAUD_TICK = 1'b0;
  logic       Rx = 1'b1;
  logic       CLR_Rec = 1'b0;
  logic [7:0] Data_Rx;
  logic       Data_Ready, parity_err, frame_err, overrun;

  int n_total = 0;
  int n_pass  = 0;

  uart_rx_ovs #(.OVS(16), .PARITY_ODD(1'b0)) dut (
    .CLK(CLK), .CLR(CLR), .BAUD_TICK(BAUD_TICK), .Rx(Rx), .CLR_Rec(CLR_Rec),
    .Data_Rx(Data_Rx), .Data_Ready(Data_Ready), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(posedge CLK);
      #1 BAUD_TICK = 1'b1;
      @(posedge CLK);
      #1 BAUD_TICK = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic hold_bit(input logic v);
    Rx = v;
    repeat (BIT_CLKS) @(posedge CLK);
    #1;
  endtask

  // glitch_bit 0..7 inverts one baud tick in the middle of that data bit; 8 = none.
  task automatic send(input logic [7:0] d, input logic par, input logic stp, input int glitch_bit);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        Rx = d[i];
        repeat (34) @(posedge CLK);
        #1 Rx = ~d[i];
        repeat (TICK_DIV) @(posedge CLK);
        #1 Rx = d[i];
        repeat (BIT_CLKS - 34 - TICK_DIV) @(posedge CLK);
        #1;
      end else begin
        hold_bit(d[i]);
      end
    end
    hold_bit(par);
    hold_bit(stp);
  endtask

  task automatic pulse_clr_rec();
    @(posedge CLK); #1 CLR_Rec = 1'b1;
    @(posedge CLK); #1 CLR_Rec = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1 CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_data", Data_Rx, 8'h00);
    chk("rst_ready", {7'd0, Data_Ready}, 8'h00);
    chk("rst_perr", {7'd0, parity_err}, 8'h00);
    chk("rst_ferr", {7'd0, frame_err}, 8'h00);
    chk("rst_ovr", {7'd0, overrun}, 8'h00);
    repeat (BIT_CLKS) @(posedge CLK);
    #1;

    send(8'hA5, 1'b0, 1'b1, 8);
    chk("a5_data", Data_Rx, 8'hA5);
    chk("a5_ready", {7'd0, Data_Ready}, 8'h01);
    chk("a5_perr", {7'd0, parity_err}, 8'h00);
    chk("a5_ferr", {7'd0, frame_err}, 8'h00);
    chk("a5_ovr", {7'd0, overrun}, 8'h00);
    pulse_clr_rec();
    chk("a5_clr_ready", {7'd0, Data_Ready}, 8'h00);
    chk("a5_clr_data", Data_Rx, 8'hA5);

    send(8'h01, 1'b0, 1'b1, 8);
    chk("p_data", Data_Rx, 8'h01);
    chk("p_perr", {7'd0, parity_err}, 8'h01);
    chk("p_ready", {7'd0, Data_Ready}, 8'h01);
    pulse_clr_rec();
    chk("p_clr_perr", {7'd0, parity_err}, 8'h00);

    send(8'h3C, 1'b0, 1'b0, 8);
    repeat (40 * BIT_CLKS) @(posedge CLK);
    #1;
    chk("f_data", Data_Rx, 8'h3C);
    chk("f_ferr", {7'd0, frame_err}, 8'h01);
    chk("f_ready", {7'd0, Data_Ready}, 8'h01);
    chk("f_ovr", {7'd0, overrun}, 8'h00);
    pulse_clr_rec();
    repeat (4 * BIT_CLKS) @(posedge CLK);
    #1;
    chk("f_low_no_rearm", {7'd0, Data_Ready}, 8'h00);
    hold_bit(1'b1);
    hold_bit(1'b1);
    chk("f_high_idle", {7'd0, Data_Ready}, 8'h00);

    Rx = 1'b0;
    repeat (4 * TICK_DIV) @(posedge CLK);
    #1 Rx = 1'b1;
    repeat (3 * BIT_CLKS) @(posedge CLK);
    #1;
    chk("g_ready", {7'd0, Data_Ready}, 8'h00);
    chk("g_ferr", {7'd0, frame_err}, 8'h00);

    send(8'h11, 1'b0, 1'b1, 8);
    send(8'h22, 1'b0, 1'b1, 8);
    chk("o_data", Data_Rx, 8'h22);
    chk("o_ovr", {7'd0, overrun}, 8'h01);
    chk("o_ready", {7'd0, Data_Ready}, 8'h01);
    pulse_clr_rec();
    chk("o_clr_ready", {7'd0, Data_Ready}, 8'h00);
    chk("o_clr_ovr", {7'd0, overrun}, 8'h00);
    chk("o_clr_flags", {6'd0, parity_err, frame_err}, 8'h00);
    chk("o_clr_data", Data_Rx, 8'h22);

`ifdef UART_RX_MAJORITY_EN
    send(8'h5A, 1'b0, 1'b1, 3);
    chk("m_data", Data_Rx, 8'h5A);
    chk("m_perr", {7'd0, parity_err}, 8'h00);
    pulse_clr_rec();
`endif

    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b1);
    repeat (BIT_CLKS / 2) @(posedge CLK);
    #1 CLR = 1'b1;
    Rx = 1'b1;
    repeat (4) @(posedge CLK);
    #1 CLR = 1'b0;
    repeat (20 * BIT_CLKS) @(posedge CLK);
    #1;
    chk("r_ready", {7'd0, Data_Ready}, 8'h00);
    chk("r_data", Data_Rx, 8'h00);
    send(8'h5A, 1'b0, 1'b1, 8);
    chk("r_new_data", Data_Rx, 8'h5A);
    chk("r_new_ready", {7'd0, Data_Ready}, 8'h01);
    chk("r_new_perr", {7'd0, parity_err}, 8'h00);
    chk("r_new_ovr", {7'd0, overrun}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
